morse_encoder_tx: RTL
=====================

Name: morse_encoder_tx

Overview:
- Converts one ASCII character into timed Morse keying on a single line, `key_out`, that drives the LED or buzzer.
- This is the transmit-side counterpart of the trainer's Morse decoder. It takes a character from the prompt/selection logic through a valid/ready handshake.
- It also presents the encoded symbol pattern on five 2-bit symbol outputs, using the decoder's symbol coding: dot = 01, dash = 10, none = 00. This allows loopback self-check.

Parameters:
- UNIT_CYCLES, 10, number of clk cycles in one Morse time unit (≥1). The board build overrides it to about 0.1 s of clocks.
- CNT_W, 24, width of the unit/cycle counter. It must hold 7*UNIT_CYCLES-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- char_in  input  8  ASCII character to send.
- char_valid  input  1  char_in is valid this cycle.
- char_ready  output  1  block is idle and can accept a character.
- key_out  output  1  1 = tone/LED on (mark), 0 = off.
- busy  output  1  a character is being sent (equals ~char_ready).
- char_done  output  1  one-cycle pulse when a character's full timing, including its trailing gap, has completed.
- char_err  output  1  one-cycle pulse when an unsupported character was accepted.
- morse_one .. morse_five  output  2 each  encoded pattern of the current/last character; 01 dot, 10 dash, 00 unused.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - key_out=0, char_done=0, char_err=0, all morse_* = 00.
  - char_ready=1 from the first clk edge after reset deasserts; in-flight character is discarded.
  - Reset has priority over char_valid.
- Handshake: a character is accepted on a rising edge where char_valid && char_ready. char_valid while busy is ignored; no buffering.
- Encoding table (combinational lookup, registered at acceptance):
  - A–Z, 0–9: ITU International Morse. Length 1–5 symbols, left-aligned into morse_one..morse_five.
  - a–z map to uppercase.
  - 0x20 (space) is a word gap with length 0.
  - Anything else is unsupported.
- morse_* update on the acceptance edge and hold until the next acceptance or reset. They are 00 for space and unsupported characters.
- FSM states: IDLE, MARK, SYMGAP, LETGAP, WORDGAP.
  - IDLE: char_ready=1.
    - On acceptance of a letter or digit: go to MARK with symbol index 0. key_out goes high in the first cycle after the acceptance edge.
    - On acceptance of a space: go to WORDGAP.
    - On acceptance of an unsupported character: stay in IDLE. Pulse char_err for the cycle after acceptance. char_ready stays 1 and key_out stays 0.
  - MARK: key_out=1 for 1*UNIT_CYCLES cycles (dot) or 3*UNIT_CYCLES cycles (dash). Then go to SYMGAP if more symbols remain, else LETGAP.
  - SYMGAP: key_out=0 for 1*UNIT_CYCLES cycles, then MARK on the next symbol.
  - LETGAP: key_out=0 for 3*UNIT_CYCLES cycles, then IDLE.
  - WORDGAP: key_out=0 for 7*UNIT_CYCLES cycles, then IDLE.
- Completion: on the transition into IDLE from LETGAP or WORDGAP, char_done=1 and char_ready=1 in the same (first IDLE) cycle.
  - A new character may be accepted in that cycle.
  - Back-to-back characters therefore have exactly a 3-unit gap, plus 1 cycle for the IDLE acceptance cycle.
- Cycle count: cycles from the acceptance edge to char_ready=1 = 1 + sum(mark units) + (n-1) + 3 units, with units multiplied by UNIT_CYCLES.
- key_out, char_ready, char_done and char_err are registered outputs; key_out is glitch-free.
- Counter: a single down- or up-counter reloaded on every state entry. No accumulated drift; each state's duration is exact.

Test Plan (UNIT_CYCLES=4):
- Reset: assert reset mid-run → key_out=0 and all morse_*=00 immediately. char_ready=1 after release; char_done/char_err stay 0.
- Send 'E' (0x45) → morse_one=01, others 00. key_out high for cycles 1–4 after acceptance, low for 12. char_done and char_ready at cycle 17.
- Send 'a' (0x61) → same as 'A': morse=01,10,00,00,00. key_out 4 on, 4 off, 12 on, 12 off. Ready at cycle 33.
- Send '0' (0x30) → morse all 10. Five 12-cycle marks separated by 4-cycle gaps, then 12 off. Ready at cycle 89.
- Send ' ' (0x20) → key_out low for 28 cycles, morse all 00, char_done at cycle 29. Send '?' (0x3F) → char_err pulses at cycle 1, no key activity, char_ready never drops.
- Back-to-back: hold char_valid with 'T' then 'E' → second character accepted in the char_done cycle; key_out off-time between marks is exactly 13 cycles. Reset during T's dash → key_out drops asynchronously, and the next 'E' sends correctly.

Source files
------------

// File: rtl/morse_encoder_tx.sv
// morse_encoder_tx: one ASCII character in, timed Morse keying out.
// The morse_* outputs carry the pattern: 01 dot, 10 dash, 00 unused.
module morse_encoder_tx #(
    parameter int UNIT_CYCLES = 10,
    parameter int CNT_W       = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       char_done,
    output logic       char_err,
    output logic [1:0] morse_one,
    output logic [1:0] morse_two,
    output logic [1:0] morse_three,
    output logic [1:0] morse_four,
    output logic [1:0] morse_five
);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        SYMGAP,
        LETGAP,
        WORDGAP
    } state_t;

    typedef enum logic [1:0] {
        K_SYM,
        K_SPACE,
        K_BAD
    } kind_t;

    localparam logic [CNT_W-1:0] DOT_CNT  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(7 * UNIT_CYCLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [4:0]       dash;
    logic [4:0]       dash_nx;
    logic [2:0]       rem;
    logic [2:0]       rem_nx;
    logic [1:0]       sym    [5];
    logic [1:0]       sym_nx [5];
    logic [7:0]       upper;
    logic [2:0]       lut_len;
    logic [4:0]       lut_dash;
    kind_t            kind;
    logic             accept;
    logic             done_nx;
    logic             err_nx;

    assign accept = char_valid && char_ready;
    assign busy   = ~char_ready;

    assign morse_one   = sym[0];
    assign morse_two   = sym[1];
    assign morse_three = sym[2];
    assign morse_four  = sym[3];
    assign morse_five  = sym[4];

    always_comb begin
        upper = char_in;
        if (char_in >= 8'h61 && char_in <= 8'h7a) begin
            upper = char_in - 8'h20;
        end
    end

    // Length plus dash mask; mask bit 4 is the first symbol sent.
    always_comb begin
        {lut_len, lut_dash} = 8'h00;
        case (upper)
            8'h41: {lut_len, lut_dash} = {3'd2, 5'b01000};
            8'h42: {lut_len, lut_dash} = {3'd4, 5'b10000};
            8'h43: {lut_len, lut_dash} = {3'd4, 5'b10100};
            8'h44: {lut_len, lut_dash} = {3'd3, 5'b10000};
            8'h45: {lut_len, lut_dash} = {3'd1, 5'b00000};
            8'h46: {lut_len, lut_dash} = {3'd4, 5'b00100};
            8'h47: {lut_len, lut_dash} = {3'd3, 5'b11000};
            8'h48: {lut_len, lut_dash} = {3'd4, 5'b00000};
            8'h49: {lut_len, lut_dash} = {3'd2, 5'b00000};
            8'h4a: {lut_len, lut_dash} = {3'd4, 5'b01110};
            8'h4b: {lut_len, lut_dash} = {3'd3, 5'b10100};
            8'h4c: {lut_len, lut_dash} = {3'd4, 5'b01000};
            8'h4d: {lut_len, lut_dash} = {3'd2, 5'b11000};
            8'h4e: {lut_len, lut_dash} = {3'd2, 5'b10000};
            8'h4f: {lut_len, lut_dash} = {3'd3, 5'b11100};
            8'h50: {lut_len, lut_dash} = {3'd4, 5'b01100};
            8'h51: {lut_len, lut_dash} = {3'd4, 5'b11010};
            8'h52: {lut_len, lut_dash} = {3'd3, 5'b01000};
            8'h53: {lut_len, lut_dash} = {3'd3, 5'b00000};
            8'h54: {lut_len, lut_dash} = {3'd1, 5'b10000};
            8'h55: {lut_len, lut_dash} = {3'd3, 5'b00100};
            8'h56: {lut_len, lut_dash} = {3'd4, 5'b00010};
            8'h57: {lut_len, lut_dash} = {3'd3, 5'b01100};
            8'h58: {lut_len, lut_dash} = {3'd4, 5'b10010};
            8'h59: {lut_len, lut_dash} = {3'd4, 5'b10110};
            8'h5a: {lut_len, lut_dash} = {3'd4, 5'b11000};
            8'h30: {lut_len, lut_dash} = {3'd5, 5'b11111};
            8'h31: {lut_len, lut_dash} = {3'd5, 5'b01111};
            8'h32: {lut_len, lut_dash} = {3'd5, 5'b00111};
            8'h33: {lut_len, lut_dash} = {3'd5, 5'b00011};
            8'h34: {lut_len, lut_dash} = {3'd5, 5'b00001};
            8'h35: {lut_len, lut_dash} = {3'd5, 5'b00000};
            8'h36: {lut_len, lut_dash} = {3'd5, 5'b10000};
            8'h37: {lut_len, lut_dash} = {3'd5, 5'b11000};
            8'h38: {lut_len, lut_dash} = {3'd5, 5'b11100};
            8'h39: {lut_len, lut_dash} = {3'd5, 5'b11110};
            default: {lut_len, lut_dash} = 8'h00;
        endcase
    end

    always_comb begin
        kind = K_BAD;
        if (lut_len != 3'd0) begin
            kind = K_SYM;
        end else if (upper == 8'h20) begin
            kind = K_SPACE;
        end
    end

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            sym_nx[k] = 2'b00;
            if (3'(k) < lut_len) begin
                sym_nx[k] = lut_dash[4-k] ? 2'b10 : 2'b01;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dash_nx  = dash;
        rem_nx   = rem;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    case (kind)
                        K_SYM: begin
                            state_nx = MARK;
                            cnt_nx   = lut_dash[4] ? DASH_CNT : DOT_CNT;
                            dash_nx  = lut_dash;
                            rem_nx   = lut_len - 3'd1;
                        end
                        K_SPACE: begin
                            state_nx = WORDGAP;
                            cnt_nx   = WORD_CNT;
                        end
                        default: err_nx = 1'b1;
                    endcase
                end
            end
            MARK: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else if (rem != 3'd0) begin
                    state_nx = SYMGAP;
                    cnt_nx   = DOT_CNT;
                    dash_nx  = {dash[3:0], 1'b0};
                    rem_nx   = rem - 3'd1;
                end else begin
                    state_nx = LETGAP;
                    cnt_nx   = DASH_CNT;
                end
            end
            SYMGAP: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    state_nx = MARK;
                    cnt_nx   = dash[4] ? DASH_CNT : DOT_CNT;
                end
            end
            LETGAP, WORDGAP: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state so key_out never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dash       <= '0;
            rem        <= '0;
            key_out    <= 1'b0;
            char_ready <= 1'b0;
            char_done  <= 1'b0;
            char_err   <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                sym[k] <= 2'b00;
            end
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            dash       <= dash_nx;
            rem        <= rem_nx;
            key_out    <= (state_nx == MARK);
            char_ready <= (state_nx == IDLE);
            char_done  <= done_nx;
            char_err   <= err_nx;
            if (accept) begin
                for (int k = 0; k < 5; k++) begin
                    sym[k] <= sym_nx[k];
                end
            end
        end
    end

endmodule
